seg_display_driver: RTL and testbench

//  Downstream consumer of the quadrature encoder position count. Converts an

---
 rtl/seg_display_driver_pkg.sv | 46 ++++
 rtl/seg_display_driver_bin2bcd_seq.sv | 93 +++++++++
 rtl/seg_display_driver.sv | 132 +++++++++++++
 tb/tb_seg_display_driver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/seg_display_driver_pkg.sv
// Shared definitions for the 7-segment display driver: converter FSM states,
// the segment code table and the elaboration-time digit-count check.
package seg_display_driver_pkg;

   // Sequential double-dabble converter states
   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } conv_state_e;

   // All segments dark
   localparam logic [6:0] SEG_OFF = 7'h00;

   // Segment pattern {g,f,e,d,c,b,a} for one BCD nibble; non-decimal nibbles are dark
   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'd0:    code = 7'h3F;
         4'd1:    code = 7'h06;
         4'd2:    code = 7'h5B;
         4'd3:    code = 7'h4F;
         4'd4:    code = 7'h66;
         4'd5:    code = 7'h6D;
         4'd6:    code = 7'h7D;
         4'd7:    code = 7'h07;
         4'd8:    code = 7'h7F;
         4'd9:    code = 7'h6F;
         default: code = SEG_OFF;
      endcase
      return code;
   endfunction

   // True when DIGITS decimal digits can hold every WIDTH-bit value (10**digits > 2**width)
   function automatic bit digits_ok(input int unsigned width, input int unsigned digits);
      longint unsigned p10;
      p10 = 64'd1;
      if (width >= 63) return 1'b0;
      // 10**19 still fits in 64 bits and already exceeds any 2**62
      for (int unsigned i = 0; (i < digits) && (i < 19); i++) begin
         p10 = p10 * 64'd10;
      end
      return p10 > (64'd1 << width);
   endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift/add-3). One input bit is consumed
// per cycle; the result stays on bcd until the next start.
module seg_display_driver_bin2bcd_seq
   import seg_display_driver_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned BcdW = 4 * DIGITS;

   conv_state_e       state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BcdW-1:0]   bcd_q, bcd_d;
   logic [BcdW-1:0]   bcd_adj;
   logic [CntW-1:0]   cnt_q, cnt_d;

   // Add-3 correction of every nibble that would overflow a decimal digit on the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Next-state and datapath control; start is honoured in IDLE and in DONE (back-to-back)
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               bin_d   = bin;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            bcd_d = {bcd_adj[BcdW-2:0], bin_q[WIDTH-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (start) begin
               bin_d   = bin;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_driver.sv
// Binary value to multiplexed common-cathode 7-segment display. Holds one
// pending value while a conversion runs, only updates the shown digits on a
// finished conversion, and scans one digit at a time.
module seg_display_driver
   import seg_display_driver_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DIGITS      = 3,
   parameter int unsigned REFRESH_DIV = 12000,
   parameter int unsigned BLANK_ZEROS = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   value,
   input  logic               value_valid,
   output logic               busy,
   output logic [6:0]         seg,
   output logic [DIGITS-1:0]  digit_en
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned RefW = $clog2(REFRESH_DIV + 1);
   localparam int unsigned IdxW = $clog2(DIGITS + 1);

   if (!digits_ok(WIDTH, DIGITS)) begin : g_digits_check
      $error("seg_display_driver: DIGITS too small to show every WIDTH-bit value");
   end

   logic              conv_start, conv_busy, conv_done;
   logic [WIDTH-1:0]  conv_bin;
   logic [BcdW-1:0]   conv_bcd;

   logic              pending_q, pending_d;
   logic [WIDTH-1:0]  pend_val_q, pend_val_d;
   logic [BcdW-1:0]   shown_q, shown_d;
   logic [RefW-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [DIGITS-1:0] digit_en_q, digit_en_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] blank;
   logic              all_zero;
   logic [3:0]        cur_nib;

   seg_display_driver_bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk    (clk),
      .reset  (reset),
      .start  (conv_start),
      .bin    (conv_bin),
      .busy   (conv_busy),
      .done   (conv_done),
      .bcd    (conv_bcd)
   );

   // Start on a fresh strobe when idle, or chain from DONE; a strobe in the DONE cycle beats
   // an older pending value
   always_comb begin
      conv_start = (value_valid && (!conv_busy || conv_done)) || (conv_done && pending_q);
      conv_bin   = value_valid ? value : pend_val_q;
   end

   // Pending slot and shown register; shown only moves on DONE so partial results never show
   always_comb begin
      pending_d  = pending_q;
      pend_val_d = pend_val_q;
      shown_d    = shown_q;
      if (conv_done) begin
         pending_d = 1'b0;
         shown_d   = conv_bcd;
      end else if (value_valid && conv_busy) begin
         pending_d  = 1'b1;
         pend_val_d = value;
      end
   end

   // Refresh counter and digit index
   always_comb begin
      cnt_d = cnt_q + RefW'(1);
      idx_d = idx_q;
      if (cnt_q == RefW'(REFRESH_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end
   end

   // Leading-zero blanking: a digit above 0 goes dark when it and every higher digit are zero
   always_comb begin
      blank    = '0;
      all_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         all_zero = all_zero & (shown_q[4*i +: 4] == 4'd0);
         blank[i] = (BLANK_ZEROS != 0) && (i != 0) && all_zero;
      end
   end

   // Digit enable and segment pattern for the current index, registered together
   always_comb begin
      cur_nib = shown_q[4*idx_q +: 4];
      seg_d   = blank[idx_q] ? SEG_OFF : seg_encode(cur_nib);
      for (int unsigned i = 0; i < DIGITS; i++) begin
         digit_en_d[i] = (idx_q == IdxW'(i));
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= 1'b0;
         pend_val_q <= '0;
         shown_q    <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         digit_en_q <= '0;
         seg_q      <= SEG_OFF;
      end else begin
         pending_q  <= pending_d;
         pend_val_q <= pend_val_d;
         shown_q    <= shown_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         digit_en_q <= digit_en_d;
         seg_q      <= seg_d;
      end
   end

   assign busy     = conv_busy;
   assign seg      = seg_q;
   assign digit_en = digit_en_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a 4-cycle refresh period.
module tb_seg_display_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] value;
   logic       value_valid;
   logic       busy;
   logic [6:0] seg;
   logic [2:0] digit_en;

   int total = 0;
   int bad   = 0;
   int rel_n = 0;   // clock edges since reset was last sampled high

   seg_display_driver #(
      .WIDTH       (8),
      .DIGITS      (3),
      .REFRESH_DIV (4),
      .BLANK_ZEROS (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .value       (value),
      .value_valid (value_valid),
      .busy        (busy),
      .seg         (seg),
      .digit_en    (digit_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference segment pattern of decimal digit d of v, with leading-zero blanking
   function automatic logic [6:0] exp_seg(input int v, input int d);
      int p;
      int dig;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      dig = (v / p) % 10;
      if ((d > 0) && (v < p)) return 7'h00;
      case (dig)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (reset) rel_n = 0;
      else rel_n++;
   endtask

   // Digit shown after the n-th edge since release: each digit lit 4 edges, scanning 0,1,2
   task automatic check_disp(input int v, input string tag);
      int idx;
      idx = ((rel_n - 1) / 4) % 3;
      check({tag, " en"}, 32'(digit_en), 32'(1 << idx));
      check({tag, " seg"}, 32'(seg), 32'(exp_seg(v, idx)));
   endtask

   // Run ncyc cycles after a strobe issued at c=0. Expected display value is v0 before c1,
   // v1 before c2, v2 afterwards; busy expected high through c=busy_last. Extra strobes are
   // issued right after the checks of cycles sc1/sc2.
   task automatic watch(input string name, input int ncyc, input int busy_last,
                        input int v0, input int c1, input int v1, input int c2, input int v2,
                        input int sc1, input int sv1, input int sc2, input int sv2);
      int ev;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         value_valid = 1'b0;
         ev = (c < c1) ? v0 : ((c < c2) ? v1 : v2);
         check_disp(ev, $sformatf("%s c%0d", name, c));
         check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(c <= busy_last));
         if (c == sc1) begin
            value       = 8'(sv1);
            value_valid = 1'b1;
         end
         if (c == sc2) begin
            value       = 8'(sv2);
            value_valid = 1'b1;
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      value       = 8'd0;
      value_valid = 1'b0;

      // 1: reset state, then idle scan of "0"
      repeat (3) tick();
      check("rst busy", 32'(busy), 32'd0);
      check("rst seg", 32'(seg), 32'd0);
      check("rst en", 32'(digit_en), 32'd0);
      reset = 1'b0;
      watch("t1", 13, 0, 0, 999, 0, 999, 0, -1, 0, -1, 0);

      // 2: single conversion of 123
      value = 8'd123; value_valid = 1'b1;
      watch("t2", 23, 9, 0, 11, 123, 999, 123, -1, 0, -1, 0);

      // 3: 255, then 7 and 42 while busy; 42 overwrites 7
      value = 8'd255; value_valid = 1'b1;
      watch("t3", 32, 18, 123, 11, 255, 20, 42, 2, 7, 4, 42);

      // 4: leading-zero blanking, inner zeros kept
      value = 8'd5; value_valid = 1'b1;
      watch("t4a", 23, 9, 42, 11, 5, 999, 5, -1, 0, -1, 0);
      value = 8'd100; value_valid = 1'b1;
      watch("t4b", 23, 9, 5, 11, 100, 999, 100, -1, 0, -1, 0);

      // 5: reset two cycles into a conversion of 200 with 77 pending
      value = 8'd200; value_valid = 1'b1;
      tick();
      value = 8'd77; value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      reset = 1'b1;
      tick();
      check("t5 rst busy", 32'(busy), 32'd0);
      check("t5 rst seg", 32'(seg), 32'd0);
      check("t5 rst en", 32'(digit_en), 32'd0);
      reset = 1'b0;
      watch("t5 idle", 13, 0, 0, 999, 0, 999, 0, -1, 0, -1, 0);
      // a dropped pending value would chain a second conversion here
      value = 8'd31; value_valid = 1'b1;
      watch("t5b", 23, 9, 0, 11, 31, 999, 31, -1, 0, -1, 0);

      // 6: strobe in the DONE cycle chains back to back
      value = 8'd9; value_valid = 1'b1;
      watch("t6", 34, 18, 31, 11, 9, 20, 250, 9, 250, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
